// File: rtl/merger_input_reader.sv
// -----------------------------------------------------------------------------
// merger_input_reader
//
// Memory-to-stream reader for the sorter datapath. On i_start it captures a
// start address and a chunk length, reads that many consecutive words from a
// synchronous single-port buffer memory (one cycle read latency) and emits
// them in address order on an AXI-stream style master port with full
// backpressure. Reads are throttled so that buffered words plus reads still
// in flight never exceed the 3-entry output FIFO.
//
// Optional feature macro: MERGER_READER_TLAST_EN
//   defined   : o_output_data_tlast marks the final beat of every chunk
//   undefined : o_output_data_tlast is held 0
//
// Ports
//   i_clock               clock, rising edge
//   i_reset_n             asynchronous active-low reset
//   i_start               single-cycle request, sampled only when idle
//   i_start_addr          first address of the chunk (captured with i_start)
//   i_chunk_size          number of words in the chunk (captured with i_start)
//   o_read_addr           memory read address
//   o_read_enable         memory read strobe
//   i_read_data           memory data, valid one cycle after o_read_enable
//   o_output_data_data    stream data
//   o_output_data_valid   stream valid
//   o_output_data_tlast   stream last-beat marker
//   i_output_data_ready   stream ready from the consumer
//   o_busy                high while a chunk is being read / drained
//   o_readback_done       one-cycle pulse at the end of each chunk
// -----------------------------------------------------------------------------
module merger_input_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_chunk_size,
  output logic [ADDR_WIDTH-1:0] o_read_addr,
  output logic                  o_read_enable,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic [DATA_WIDTH-1:0] o_output_data_data,
  output logic                  o_output_data_valid,
  output logic                  o_output_data_tlast,
  input  logic                  i_output_data_ready,
  output logic                  o_busy,
  output logic                  o_readback_done
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READING  = 2'd1,
    ST_DRAINING = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);

  // Control state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_chunk_size;
  logic [ADDR_WIDTH-1:0] r_issued;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic                  w_issue;
  logic                  w_capture;
  logic [ADDR_WIDTH-1:0] w_base_addr;
  logic [ADDR_WIDTH-1:0] w_base_issued;

  // Credit = FIFO occupancy + reads whose data has not yet reached the FIFO
  logic [1:0]            r_credit;
  logic [1:0]            w_credit_after_pop;
  logic [1:0]            w_credit_nxt;

  // Read pipeline: r_read_enable is the address phase, r_data_phase marks
  // the cycle in which i_read_data carries the corresponding word.
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic                  r_read_enable;
  logic                  r_data_phase;

  // Output FIFO, entry 0 is always the head
  logic [DATA_WIDTH-1:0] r_fifo_data [3];
  logic [DATA_WIDTH-1:0] w_fifo_data_nxt [3];
  logic [1:0]            r_fifo_cnt;
  logic [1:0]            w_fifo_cnt_nxt;
  logic [1:0]            w_wr_idx;
  logic                  r_valid;
  logic                  w_pop;

  logic                  r_busy;
  logic                  r_done;

`ifdef MERGER_READER_TLAST_EN
  logic [ADDR_WIDTH-1:0] w_size;
  logic                  r_read_last;
  logic                  r_data_last;
  logic [2:0]            r_fifo_last;
  logic [2:0]            w_fifo_last_nxt;
  logic                  r_tlast;
`endif

  assign w_pop              = r_valid & i_output_data_ready;
  assign w_credit_after_pop = r_credit - {1'b0, w_pop};
  assign w_credit_nxt       = w_credit_after_pop + {1'b0, w_issue};

  // While idle the request inputs are used directly so the first read can be
  // issued in the cycle right after the accepting edge.
  assign w_base_addr   = w_capture ? i_start_addr : r_next_addr;
  assign w_base_issued = w_capture ? ADDR_ZERO    : r_issued;

  // Next-state, read-issue and capture decisions
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_capture = 1'b1;
          if (i_chunk_size == ADDR_ZERO) begin
            w_state_nxt = ST_DONE;
          end else begin
            // Nothing is buffered or in flight when idle.
            w_issue     = 1'b1;
            w_state_nxt = ST_READING;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READING: begin
        if (r_issued == r_chunk_size) begin
          w_state_nxt = ST_DRAINING;
        end else if (w_credit_after_pop <= 2'd2) begin
          w_issue = 1'b1;
        end else begin
          w_issue = 1'b0;
        end
      end
      ST_DRAINING: begin
        // Only the head word remains and it leaves this cycle.
        if (w_pop && (r_credit == 2'd1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAINING;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FIFO next contents: pop shifts toward the head, the returning word lands
  // behind whatever remains after the pop.
  always_comb begin
    w_fifo_data_nxt = r_fifo_data;
    w_fifo_cnt_nxt  = r_fifo_cnt;
    w_wr_idx        = r_fifo_cnt - {1'b0, w_pop};
`ifdef MERGER_READER_TLAST_EN
    w_fifo_last_nxt = r_fifo_last;
`endif
    if (w_pop) begin
      w_fifo_data_nxt[0] = r_fifo_data[1];
      w_fifo_data_nxt[1] = r_fifo_data[2];
      w_fifo_cnt_nxt     = w_wr_idx;
`ifdef MERGER_READER_TLAST_EN
      w_fifo_last_nxt    = {1'b0, r_fifo_last[2:1]};
`endif
    end else begin
      w_fifo_cnt_nxt = r_fifo_cnt;
    end
    if (r_data_phase) begin
      case (w_wr_idx)
        2'd0:    w_fifo_data_nxt[0] = i_read_data;
        2'd1:    w_fifo_data_nxt[1] = i_read_data;
        2'd2:    w_fifo_data_nxt[2] = i_read_data;
        default: w_fifo_data_nxt[2] = i_read_data;
      endcase
`ifdef MERGER_READER_TLAST_EN
      case (w_wr_idx)
        2'd0:    w_fifo_last_nxt[0] = r_data_last;
        2'd1:    w_fifo_last_nxt[1] = r_data_last;
        2'd2:    w_fifo_last_nxt[2] = r_data_last;
        default: w_fifo_last_nxt[2] = r_data_last;
      endcase
`endif
      w_fifo_cnt_nxt = w_wr_idx + 2'd1;
    end else begin
      w_fifo_cnt_nxt = w_fifo_cnt_nxt;
    end
  end

`ifdef MERGER_READER_TLAST_EN
  assign w_size = w_capture ? i_chunk_size : r_chunk_size;
`endif

  // Control and read-pipeline registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_chunk_size  <= ADDR_ZERO;
      r_issued      <= ADDR_ZERO;
      r_next_addr   <= ADDR_ZERO;
      r_credit      <= 2'd0;
      r_read_addr   <= ADDR_ZERO;
      r_read_enable <= 1'b0;
      r_data_phase  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      if (w_capture) begin
        r_chunk_size <= i_chunk_size;
      end
      r_issued      <= w_base_issued + (w_issue ? ADDR_ONE : ADDR_ZERO);
      r_next_addr   <= w_base_addr + (w_issue ? ADDR_ONE : ADDR_ZERO);
      r_credit      <= w_credit_nxt;
      if (w_issue) begin
        r_read_addr <= w_base_addr;
      end
      r_read_enable <= w_issue;
      r_data_phase  <= r_read_enable;
      r_busy        <= (w_state_nxt == ST_READING) || (w_state_nxt == ST_DRAINING);
      r_done        <= (w_state_nxt == ST_DONE);
    end
  end

  // Output FIFO registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fifo_data <= '{default: '0};
      r_fifo_cnt  <= 2'd0;
      r_valid     <= 1'b0;
    end else begin
      r_fifo_data <= w_fifo_data_nxt;
      r_fifo_cnt  <= w_fifo_cnt_nxt;
      r_valid     <= (w_fifo_cnt_nxt != 2'd0);
    end
  end

`ifdef MERGER_READER_TLAST_EN
  // Last-word marker travelling alongside each read through the pipeline
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_read_last <= 1'b0;
      r_data_last <= 1'b0;
      r_fifo_last <= 3'b000;
      r_tlast     <= 1'b0;
    end else begin
      r_read_last <= w_issue && ((w_base_issued + ADDR_ONE) == w_size);
      r_data_last <= r_read_last;
      r_fifo_last <= w_fifo_last_nxt;
      r_tlast     <= w_fifo_last_nxt[0] && (w_fifo_cnt_nxt != 2'd0);
    end
  end

  assign o_output_data_tlast = r_tlast;
`else
  assign o_output_data_tlast = 1'b0;
`endif

  assign o_read_addr         = r_read_addr;
  assign o_read_enable       = r_read_enable;
  assign o_output_data_data  = r_fifo_data[0];
  assign o_output_data_valid = r_valid;
  assign o_busy              = r_busy;
  assign o_readback_done     = r_done;

endmodule

// File: tb/tb_merger_input_reader.sv
module tb_merger_input_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] chunk_size;
  logic [15:0] read_addr;
  logic        read_enable;
  logic [31:0] read_data;
  logic [31:0] data;
  logic        valid;
  logic        tlast;
  logic        ready;
  logic        busy;
  logic        done;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Monitor logs
  logic [31:0] beat_q[$];
  int          beat_cyc_q[$];
  logic        last_q[$];
  logic [15:0] rd_q[$];
  int          done_q[$];
  int          rd_total   = 0;
  int          beat_total = 0;
  int          max_out    = 0;
  int          hold_viol  = 0;
  logic        prev_hold  = 1'b0;
  logic [31:0] prev_data  = 32'h0;

  merger_input_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .i_clock             (clk),
    .i_reset_n           (rst_n),
    .i_start             (start),
    .i_start_addr        (start_addr),
    .i_chunk_size        (chunk_size),
    .o_read_addr         (read_addr),
    .o_read_enable       (read_enable),
    .i_read_data         (read_data),
    .o_output_data_data  (data),
    .o_output_data_valid (valid),
    .o_output_data_tlast (tlast),
    .i_output_data_ready (ready),
    .o_busy              (busy),
    .o_readback_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer memory: word at addr holds addr + 0x100, one cycle latency
  always @(posedge clk) begin
    if (read_enable) read_data <= 32'h100 + {16'h0, read_addr};
  end

  // Mid-cycle observer of reads, beats and done pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (valid !== 1'b1 || data !== prev_data)) hold_viol++;
      if (read_enable === 1'b1) begin
        rd_q.push_back(read_addr);
        rd_total++;
      end
      if (rd_total - beat_total > max_out) max_out = rd_total - beat_total;
      if (valid === 1'b1 && ready === 1'b1) begin
        beat_q.push_back(data);
        beat_cyc_q.push_back(cyc);
        last_q.push_back(tlast);
        beat_total++;
      end
      if (done === 1'b1) done_q.push_back(cyc);
      prev_hold = (valid === 1'b1) && (ready === 1'b0);
      prev_data = data;
    end
  end

  task automatic clear_logs();
    beat_q.delete(); beat_cyc_q.delete(); last_q.delete();
    rd_q.delete(); done_q.delete();
    rd_total = 0; beat_total = 0; max_out = 0; hold_viol = 0;
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] s, output int n);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; chunk_size = s; n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (done_q.size() >= target) break;
    end
    n_vec++;
    if (done_q.size() < target) begin
      n_miss++;
      $display("FAIL %s_timeout: done pulses %0d, required %0d", name, done_q.size(), target);
    end
  endtask

  // Checks the beat log against addr+0x100 words starting at base
  task automatic check_words(input logic [15:0] base, input int len, input string name);
    logic [15:0] a;
    logic        exp_last;
    n_vec++;
    if (beat_q.size() !== len) begin
      n_miss++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, beat_q.size(), len);
    end
    for (int i = 0; i < len && i < beat_q.size(); i++) begin
      a = base + i[15:0];
      n_vec++;
      if (beat_q[i] !== 32'h100 + {16'h0, a}) begin
        n_miss++;
        $display("FAIL %s_data[%0d]: got %h, required %h", name, i, beat_q[i], 32'h100 + {16'h0, a});
      end
`ifdef MERGER_READER_TLAST_EN
      exp_last = (i == len - 1);
`else
      exp_last = 1'b0;
`endif
      n_vec++;
      if (last_q[i] !== exp_last) begin
        n_miss++;
        $display("FAIL %s_tlast[%0d]: got %b, required %b", name, i, last_q[i], exp_last);
      end
    end
    n_vec++;
    if (rd_total !== len) begin
      n_miss++;
      $display("FAIL %s_reads: got %0d read strobes, required %0d", name, rd_total, len);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_addr = 16'h0; chunk_size = 16'h0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({read_addr, read_enable, valid, data, tlast, busy, done} !== 53'h0) begin
      n_miss++;
      $display("FAIL reset_outputs: got %h, required 0",
               {read_addr, read_enable, valid, data, tlast, busy, done});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    clear_logs(); ready = 1'b1;
    pulse_start(16'h0000, 16'd8, n);
    n_vec++;
    if (busy !== 1'b1) begin
      n_miss++; $display("FAIL basic_busy: got %b, required 1", busy);
    end
    wait_done(1, "basic");
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++; $display("FAIL basic_busy_done: got %b, required 0", busy);
    end
    check_words(16'h0000, 8, "basic");
    for (int i = 0; i < beat_cyc_q.size(); i++) begin
      n_vec++;
      if (beat_cyc_q[i] !== n + 3 + i) begin
        n_miss++;
        $display("FAIL basic_beat_cycle[%0d]: got %0d, required %0d", i, beat_cyc_q[i] - n, 3 + i);
      end
    end
    n_vec++;
    if (done_q.size() > 0 && done_q[0] !== n + 11) begin
      n_miss++; $display("FAIL basic_done_cycle: got N+%0d, required N+11", done_q[0] - n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    // Previous chunk just pulsed done; this start lands in the following cycle
    clear_logs();
    pulse_start(16'h0010, 16'd3, n);
    wait_done(1, "b2b");
    check_words(16'h0010, 3, "b2b");
    n_vec++;
    if (beat_cyc_q.size() > 0 && beat_cyc_q[0] !== n + 3) begin
      n_miss++; $display("FAIL b2b_first_beat: got N+%0d, required N+3", beat_cyc_q[0] - n);
    end
    n_vec++;
    if (done_q.size() > 0 && done_q[0] !== n + 6) begin
      n_miss++; $display("FAIL b2b_done_cycle: got N+%0d, required N+6", done_q[0] - n);
    end
  endtask

  task automatic test_backpressure();
    int k;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; start_addr = 16'h0000; chunk_size = 16'd8;
    ready = 1'($urandom_range(0, 1));
    for (k = 0; k < 400 && done_q.size() == 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b1;
    n_vec++;
    if (done_q.size() == 0) begin
      n_miss++; $display("FAIL bp_timeout: no done pulse within 400 cycles");
    end
    check_words(16'h0000, 8, "bp");
    n_vec++;
    if (max_out > 3) begin
      n_miss++; $display("FAIL bp_outstanding: got %0d, required <= 3", max_out);
    end
    n_vec++;
    if (hold_viol !== 0) begin
      n_miss++; $display("FAIL bp_hold: got %0d stability violations, required 0", hold_viol);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [15:0] exp_a [4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    clear_logs(); ready = 1'b1;
    pulse_start(16'hFFFE, 16'd4, n);
    wait_done(1, "wrap");
    check_words(16'hFFFE, 4, "wrap");
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      n_vec++;
      if (rd_q[i] !== exp_a[i]) begin
        n_miss++; $display("FAIL wrap_addr[%0d]: got %h, required %h", i, rd_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_zero();
    int n;
    clear_logs(); ready = 1'b1;
    pulse_start(16'h0033, 16'd0, n);
    wait_done(1, "zero");
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (rd_total !== 0 || beat_total !== 0) begin
      n_miss++; $display("FAIL zero_activity: got %0d reads %0d beats, required 0 0", rd_total, beat_total);
    end
    n_vec++;
    if (done_q.size() > 0 && done_q[0] !== n + 1) begin
      n_miss++; $display("FAIL zero_done_cycle: got N+%0d, required N+1", done_q[0] - n);
    end
  endtask

  task automatic test_restart_ignored();
    int n;
    int k;
    clear_logs(); ready = 1'b1;
    pulse_start(16'h0000, 16'd16, n);
    for (k = 0; k < 100 && beat_q.size() < 5; k++) begin
      @(posedge clk); #1;
    end
    start = 1'b1; start_addr = 16'h0050; chunk_size = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, "restart");
    repeat (6) @(posedge clk);
    #1;
    check_words(16'h0000, 16, "restart");
    n_vec++;
    if (done_q.size() !== 1) begin
      n_miss++; $display("FAIL restart_done_count: got %0d, required 1", done_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int k;
    clear_logs(); ready = 1'b1;
    pulse_start(16'h0020, 16'd8, n);
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (beat_q.size() >= 3) break;
    end
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({read_addr, read_enable, valid, data, tlast, busy, done} !== 53'h0) begin
      n_miss++;
      $display("FAIL midreset_outputs: got %h, required 0",
               {read_addr, read_enable, valid, data, tlast, busy, done});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (done_q.size() !== 0) begin
      n_miss++; $display("FAIL midreset_done: got %0d done pulses, required 0", done_q.size());
    end
    clear_logs(); ready = 1'b1;
    pulse_start(16'h0040, 16'd4, n);
    wait_done(1, "postreset");
    check_words(16'h0040, 4, "postreset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_zero();
    test_restart_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
